// File: rtl/operand_fetch.sv
// Operand fetch: register file with write bypass, operand B select and the ID/EX
// pipeline register under a valid/ready handshake with stall and flush.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_alusrc,
  input  logic              id_immsign,
  input  logic [3:0]        id_aluop,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [3:0]        ex_aluop,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_regwrite
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];

  logic [DATA_W-1:0] opa, rt_val, opb, imm_ext;
  logic              accept;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [3:0]        ex_aluop_q, ex_aluop_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic              ex_regwrite_q, ex_regwrite_d;

  // Register file write port; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign imm_ext = {{(DATA_W - IMM_W){id_immsign & id_imm[IMM_W-1]}}, id_imm};

  // Combinational reads with same-cycle writeback bypass; r0 reads zero.
  always_comb begin
    opa    = '0;
    rt_val = '0;
    if (id_rs != '0) begin
      opa = (wb_we && (wb_addr == id_rs)) ? wb_data : regs_q[id_rs];
    end
    if (id_rt != '0) begin
      rt_val = (wb_we && (wb_addr == id_rt)) ? wb_data : regs_q[id_rt];
    end
    opb = id_alusrc ? imm_ext : rt_val;
  end

  assign id_ready = ~ex_valid_q | ex_ready;
  assign accept   = id_valid & id_ready & ~flush;

  // Pipeline register next state: flush beats accept beats drain; otherwise hold.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    ex_aluop_d    = ex_aluop_q;
    ex_rd_d       = ex_rd_q;
    ex_regwrite_d = ex_regwrite_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d    = 1'b1;
      ex_a_d        = opa;
      ex_b_d        = opb;
      ex_aluop_d    = id_aluop;
      ex_rd_d       = id_rd;
      ex_regwrite_d = id_regwrite;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID/EX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_aluop_q    <= '0;
      ex_rd_q       <= '0;
      ex_regwrite_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_aluop_q    <= ex_aluop_d;
      ex_rd_q       <= ex_rd_d;
      ex_regwrite_q <= ex_regwrite_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_aluop    = ex_aluop_q;
  assign ex_rd       = ex_rd_q;
  assign ex_regwrite = ex_regwrite_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [15:0] id_imm = '0;
  logic        id_alusrc = 1'b0;
  logic        id_immsign = 1'b0;
  logic [3:0]  id_aluop = '0;
  logic [4:0]  id_rd = '0;
  logic        id_regwrite = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;

  int n_tests = 0;
  int n_fail  = 0;

  operand_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_imm     (id_imm),
    .id_alusrc  (id_alusrc),
    .id_immsign (id_immsign),
    .id_aluop   (id_aluop),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .flush      (flush),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_ready   (ex_ready),
    .ex_valid   (ex_valid),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_aluop   (ex_aluop),
    .ex_rd      (ex_rd),
    .ex_regwrite(ex_regwrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_aluop;
  logic [4:0]  m_rd;
  logic        m_rw;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we && wb_addr == idx) return wb_data;
    return mregs[idx];
  endfunction

  // Model: what the stage holds after each edge, from the handshake rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      m_valid = 1'b0; m_a = 0; m_b = 0; m_aluop = 0; m_rd = 0; m_rw = 0;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (id_valid && (!m_valid || ex_ready)) begin
        m_valid = 1'b1;
        m_a     = mread(id_rs);
        if (!id_alusrc) m_b = mread(id_rt);
        else if (id_immsign) m_b = 32'($signed(id_imm));
        else m_b = 32'(id_imm);
        m_aluop = id_aluop;
        m_rd    = id_rd;
        m_rw    = id_regwrite;
      end else if (ex_ready) begin
        m_valid = 1'b0;
      end
      if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
    end
  end

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("m_id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
      chk("m_ex_a", ex_a, m_a);
      chk("m_ex_b", ex_b, m_b);
      chk("m_ex_aluop", 32'(ex_aluop), 32'(m_aluop));
      chk("m_ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("m_ex_regwrite", 32'(ex_regwrite), 32'(m_rw));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    id_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic alusrc, input logic immsign, input logic [3:0] op,
                       input logic [4:0] rd);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_imm = imm; id_alusrc = alusrc;
    id_immsign = immsign; id_aluop = op; id_rd = rd; id_regwrite = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    quiet();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_ex_a", ex_a, 32'd0);
    chk("reset_id_ready", 32'(id_ready), 32'd1);

    // Write then read.
    wb(5'd5, 32'h1234_5678);
    tick();
    quiet();
    instr(5'd5, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0010, 5'd3);
    tick();
    chk("wr_ex_valid", 32'(ex_valid), 32'd1);
    chk("wr_ex_a", ex_a, 32'h1234_5678);
    chk("wr_ex_b", ex_b, 32'd0);
    chk("wr_ex_rd", 32'(ex_rd), 32'd3);

    // Same-cycle bypass.
    instr(5'd7, 5'd7, 16'h0, 1'b0, 1'b0, 4'b0001, 5'd4);
    wb(5'd7, 32'hDEAD_BEEF);
    tick();
    chk("byp_ex_a", ex_a, 32'hDEAD_BEEF);
    chk("byp_ex_b", ex_b, 32'hDEAD_BEEF);

    // r0 write dropped, even with same-cycle read.
    instr(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0000, 5'd1);
    wb(5'd0, 32'hFFFF_FFFF);
    tick();
    chk("r0_bypass_a", ex_a, 32'd0);
    wb_we = 1'b0;
    tick();
    chk("r0_stored_b", ex_b, 32'd0);

    // Immediate extension.
    instr(5'd5, 5'd7, 16'h8001, 1'b1, 1'b1, 4'b1100, 5'd2);
    tick();
    chk("imm_sext", ex_b, 32'hFFFF_8001);
    chk("imm_aluop", 32'(ex_aluop), 32'hC);
    instr(5'd5, 5'd7, 16'h8001, 1'b1, 1'b0, 4'b1111, 5'd2);
    tick();
    chk("imm_zext", ex_b, 32'h0000_8001);
    chk("undef_aluop", 32'(ex_aluop), 32'hF);

    // Stall three cycles, then release.
    instr(5'd5, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0111, 5'd6);
    tick();
    instr(5'd7, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0110, 5'd8);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_id_ready", 32'(id_ready), 32'd0);
      tick();
      chk("stall_ex_a", ex_a, 32'h1234_5678);
      chk("stall_ex_aluop", 32'(ex_aluop), 32'h7);
      chk("stall_ex_valid", 32'(ex_valid), 32'd1);
    end
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", 32'(id_ready), 32'd1);
    tick();
    chk("release_ex_a", ex_a, 32'hDEAD_BEEF);
    chk("release_ex_aluop", 32'(ex_aluop), 32'h6);

    // Flush with a valid stage and a valid incoming instruction; writeback still lands.
    instr(5'd5, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0000, 5'd9);
    flush = 1'b1;
    ex_ready = 1'b0;
    wb(5'd9, 32'hCAFE_F00D);
    tick();
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_ex_a_hold", ex_a, 32'hDEAD_BEEF);
    quiet();
    tick();
    chk("flush_no_ghost", 32'(ex_valid), 32'd0);
    instr(5'd9, 5'd0, 16'h0, 1'b0, 1'b0, 4'b0010, 5'd10);
    tick();
    chk("flush_wb_landed", ex_a, 32'hCAFE_F00D);

    // Asynchronous reset mid-stream.
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_ex_valid", 32'(ex_valid), 32'd0);
    chk("areset_ex_a", ex_a, 32'd0);
    tick();
    rst_n = 1'b1;
    quiet();
    instr(5'd5, 5'd9, 16'h0, 1'b0, 1'b0, 4'b0010, 5'd1);
    tick();
    chk("areset_r5", ex_a, 32'd0);
    chk("areset_r9", ex_b, 32'd0);

    // Randomized traffic; small register range to provoke bypass collisions.
    for (int c = 0; c < 3000; c++) begin
      id_valid    = ($urandom_range(0, 9) < 7);
      id_rs       = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      id_rt       = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      id_imm      = 16'($urandom);
      id_alusrc   = 1'($urandom_range(0, 1));
      id_immsign  = 1'($urandom_range(0, 1));
      id_aluop    = 4'($urandom_range(0, 15));
      id_rd       = 5'($urandom_range(0, 31));
      id_regwrite = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 15) == 0);
      ex_ready    = ($urandom_range(0, 9) < 6);
      wb_we       = 1'($urandom_range(0, 1));
      wb_addr     = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wb_data     = $urandom;
      tick();
    end

    quiet();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
